// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between pipeline writeback
//               and a queued long-latency result stream, with a starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         pipe_write,
    input  logic [REG_W-1:0]             pipe_reg,
    input  logic [DATA_W-1:0]            pipe_data,
    input  logic                         lu_valid,
    output logic                         lu_ready,
    input  logic [REG_W-1:0]             lu_reg,
    input  logic [DATA_W-1:0]            lu_data,
    output logic                         rf_we,
    output logic [REG_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         stall_pipe,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int STV_W = $clog2(STARVE_MAX);

    localparam logic [CNT_W-1:0] c_DEPTH      = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] c_STARVE_TOP = STV_W'(STARVE_MAX - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FORCE = 1'b1;

    logic [REG_W-1:0]  r_mem_reg  [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    logic w_fifo_ne;
    logic w_pipe_valid;
    logic w_grant_fifo;
    logic w_grant_pipe;
    logic w_enq;
    logic w_deq;

    // The pipeline can only win while IDLE, so a non-empty FIFO always wins in FORCE.
    assign w_fifo_ne    = (r_count != '0);
    assign w_pipe_valid = pipe_write && !flush && (pipe_reg != '0) && (r_state == S_IDLE);
    assign w_grant_fifo = w_fifo_ne && ((r_state == S_FORCE) || !w_pipe_valid);
    assign w_grant_pipe = w_pipe_valid && !w_grant_fifo;
    assign w_deq        = w_grant_fifo;

    // Backpressure looks only at registered occupancy; r0 results complete the handshake but are dropped.
    assign lu_ready     = (r_count < c_DEPTH);
    assign w_enq        = lu_valid && lu_ready && (lu_reg != '0);
    assign fifo_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_reg[r_wr_ptr]  <= lu_reg;
            r_mem_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_deq || !w_fifo_ne) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_TOP) begin
                r_starve <= r_starve + STV_W'(1);
            end

            if (w_grant_fifo) begin
                rf_we    <= 1'b1;
                rf_waddr <= r_mem_reg[r_rd_ptr];
                rf_wdata <= r_mem_data[r_rd_ptr];
            end else if (w_grant_pipe) begin
                rf_we    <= 1'b1;
                rf_waddr <= pipe_reg;
                rf_wdata <= pipe_data;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_starve == c_STARVE_TOP) && w_fifo_ne && !w_grant_fifo) begin
                    w_state_nxt = S_FORCE;
                end
            end
            S_FORCE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall_pipe = (r_state == S_FORCE);
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Randomized scoreboard bench for wb_port_arbiter against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              pipe_write = 1'b0;
    logic [REG_W-1:0]  pipe_reg = '0;
    logic [DATA_W-1:0] pipe_data = '0;
    logic              lu_valid = 1'b0;
    logic              lu_ready;
    logic [REG_W-1:0]  lu_reg = '0;
    logic [DATA_W-1:0] lu_data = '0;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_pipe;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pipe_write(pipe_write), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_pipe(stall_pipe), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [REG_W-1:0] r; logic [DATA_W-1:0] d; } ent_t;
    typedef struct { int cyc; logic [REG_W-1:0] r; logic [DATA_W-1:0] d; } exp_t;

    ent_t mq[$];        // model of queued long-latency results
    exp_t wq[$];        // expected register-file writes, stamped with the cycle they appear
    ent_t lu_pend[$];   // results waiting to be offered on the lu interface

    int                cyc = 0;
    bit                m_force = 1'b0;
    int                m_starve = 0;
    logic [REG_W-1:0]  m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    bit                m_ne, m_pv, m_gf, m_go, m_acc;
    exp_t              m_e;
    exp_t              mon_e;
    bit                mon_exp_we;
    bit                lu_rdy_drv = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one step per clock, from the arbitration rules.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            wq.delete();
            m_force  = 1'b0;
            m_starve = 0;
            m_waddr  = '0;
            m_wdata  = '0;
        end else begin
            m_ne  = (mq.size() != 0);
            m_pv  = pipe_write && !flush && (pipe_reg != 0) && !m_force;
            m_acc = lu_valid && (mq.size() < DEPTH) && (lu_reg != 0);
            m_gf  = m_ne && (m_force || !m_pv);
            if (m_gf) begin
                m_e = '{cyc: cyc, r: mq[0].r, d: mq[0].d};
                wq.push_back(m_e);
                m_waddr = mq[0].r;
                m_wdata = mq[0].d;
            end else if (m_pv) begin
                m_e = '{cyc: cyc, r: pipe_reg, d: pipe_data};
                wq.push_back(m_e);
                m_waddr = pipe_reg;
                m_wdata = pipe_data;
            end
            m_go = !m_force && m_ne && !m_gf && (m_starve == STARVE_MAX - 1);
            if (m_gf || !m_ne) m_starve = 0;
            else if (m_starve < STARVE_MAX - 1) m_starve++;
            m_force = m_go;
            if (m_gf) void'(mq.pop_front());
            if (m_acc) mq.push_back('{r: lu_reg, d: lu_data});
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        mon_exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
        chk("rf_we", {63'd0, rf_we}, {63'd0, mon_exp_we});
        if (mon_exp_we) begin
            mon_e = wq.pop_front();
            chk("rf_waddr_write", 64'(rf_waddr), 64'(mon_e.r));
            chk("rf_wdata_write", 64'(rf_wdata), 64'(mon_e.d));
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            mon_e = wq.pop_front();
            chk("stale_expected_write", 64'(mon_e.cyc), 64'(cyc));
        end
        chk("rf_waddr_hold", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata_hold", 64'(rf_wdata), 64'(m_wdata));
        chk("stall_pipe", {63'd0, stall_pipe}, {63'd0, m_force});
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("lu_ready", {63'd0, lu_ready}, {63'd0, (mq.size() < DEPTH)});
    end

    task automatic step(input bit pw, input logic [REG_W-1:0] preg,
                        input logic [DATA_W-1:0] pdata, input bit fl, input bit lu_en);
        @(negedge clk);
        #1;
        if (lu_valid && lu_rdy_drv && lu_pend.size() > 0) void'(lu_pend.pop_front());
        pipe_write = pw;
        pipe_reg   = preg;
        pipe_data  = pdata;
        flush      = fl;
        if (lu_en && lu_pend.size() > 0) begin
            lu_valid   = 1'b1;
            lu_reg     = lu_pend[0].r;
            lu_data    = lu_pend[0].d;
            lu_rdy_drv = lu_ready;
        end else begin
            lu_valid   = 1'b0;
            lu_rdy_drv = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst        = 1'b1;
        lu_valid   = 1'b0;
        lu_rdy_drv = 1'b0;
        pipe_write = 1'b0;
        lu_pend.delete();
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2);
        @(negedge clk);
        #2;
        chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
        chk("reset_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("reset_fifo_count", 64'(fifo_count), 64'd0);

        // pipeline only
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("pipe_only_we", {63'd0, rf_we}, 64'd1);
        chk("pipe_only_addr", 64'(rf_waddr), 64'd5);
        chk("pipe_only_data", 64'(rf_wdata), 64'hDEADBEEF);

        // flush, r0 pipeline write, r0 long-latency result
        step(1'b1, 5'd9, 32'h11, 1'b1, 1'b0);
        step(1'b1, 5'd0, 32'h22, 1'b0, 1'b0);
        lu_pend.push_back('{r: 5'd0, d: 32'h33});
        repeat (4) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("r0_not_enqueued", 64'(fifo_count), 64'd0);

        // idle drain
        lu_pend.push_back('{r: 5'd7, d: 32'h1234});
        repeat (5) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // fill under constant pipeline traffic, then starvation and forced drain
        for (int i = 0; i < 5; i++) lu_pend.push_back('{r: 5'(10 + i), d: 32'hA000 + i});
        for (int i = 0; i < 5; i++) step(1'b1, 5'(1 + i), 32'hB000 + i, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_ready", {63'd0, lu_ready}, 64'd0);
        for (int i = 0; i < 30; i++) step(1'b1, 5'(1 + (i % 31)), 32'hC000 + i, 1'b0, 1'b1);
        repeat (10) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // reset mid-operation with queued entries
        for (int i = 0; i < 3; i++) lu_pend.push_back('{r: 5'(20 + i), d: 32'hE000 + i});
        repeat (5) step(1'b1, 5'd3, 32'hF00D, 1'b0, 1'b1);
        do_reset(1);
        @(negedge clk);
        #2;
        chk("midreset_count", 64'(fifo_count), 64'd0);
        chk("midreset_we", {63'd0, rf_we}, 64'd0);
        chk("midreset_stall", {63'd0, stall_pipe}, 64'd0);
        repeat (10) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(1);
            if ($urandom_range(0, 3) == 0 && lu_pend.size() < 3)
                lu_pend.push_back('{r: 5'($urandom_range(0, 31)), d: $urandom});
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0);
        end

        repeat (40) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("lu_pending_drained", 64'(lu_pend.size()), 64'd0);
        chk("fifo_drained", 64'(fifo_count), 64'd0);
        chk("expected_writes_drained", 64'(wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
